mux_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4_1_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one W-bit 4:1 mux datapath among N valid/ready requesters.
//  Picks one winner, drives the mux select, and holds the grant for a burst of up to MAX_BURST beats.
//  Sits in front of the downstream consumer; the mux select is exported for debug/steering.
// PARAMETERS
//  N          4   number of requesters (>=2); SW = $clog2(N)
//  W          4   data width per requester
//  MAX_BURST  4   max beats per grant (>=1)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   N     per-requester valid
//  in_data    in   N*W   requester i data = in_data[i*W +: W]
//  in_ready   out  N     per-requester ready (one-hot or zero)
//  out_valid  out  1     output beat valid
//  out_data   out  W     output data
//  out_ready  in   1     downstream ready
//  sel        out  SW    current grant index (mux select)
//  busy       out  1     1 while in GRANT
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, ptr=0, sel=0, beat_cnt=0;
//    out_valid=0, out_data=0, in_ready=0, busy=0.
//  - Beat = out_valid && out_ready (equivalently, in_valid[sel] && in_ready[sel]).
//  - IDLE: out_valid=0, in_ready=0, out_data=0.
//    If |in_valid, winner = first i with in_valid[i], scanning ptr, ptr+1, ... mod N.
//    Registers sel<=winner, beat_cnt<=0, state<=GRANT.
//  - GRANT: busy=1; out_valid=in_valid[sel]; out_data=in_data[sel];
//    in_ready[sel]=out_ready, all other in_ready=0.
//    Each beat: beat_cnt++.
//  - Release (GRANT->IDLE, ptr<=(sel+1) mod N) occurs on either condition:
//    (a) a beat with beat_cnt==MAX_BURST-1;
//    (b) in_valid[sel]==0 in any GRANT cycle (requester dropped; no beat that cycle).
//  - Latency: request seen in IDLE at edge t -> first beat possible in cycle t+1.
//    One IDLE bubble cycle between consecutive grants.
//  - Non-granted in_valid is ignored; its request is held by the requester until
//    served (standard valid/ready: valid must not drop before ready).
//  - out_ready low stalls: no beat counted, grant held; no timeout.
//  - MAX_BURST=1: exactly one beat per grant.
//  - ptr wraps N-1 -> 0. Starvation-free: any held request is granted within N grants.
//  - Reset mid-burst: the in-flight beat is not transferred; all state returns to
//    reset values immediately.
// CONFIGURATION
//  ARB_OUT_REG_EN defined: one-entry output register slice.
//   - out_valid/out_data registered.
//   - in_ready[sel] = !out_valid_q || out_ready; full throughput, +1 cycle latency.
//   - Beats/release counted on the input-side handshake.
//   - The held entry drains even after release/IDLE.
//   - Reset clears the slice.
//  ARB_OUT_REG_EN undefined: combinational path as described above.
// TESTING
//  1. Single req: in_valid=0001, out_ready=1, data 0xA..
//     -> sel=0, 4 beats, release, ptr=1, IDLE bubble, regrant req0.
//  2. All requesting (1111), out_ready=1 constantly
//     -> grant order 0,1,2,3,0; 4 beats each; out_data matches source.
//  3. Grant to 2 with in_valid[2] dropped after beat 2
//     -> release after 2 beats, ptr=3; req3 granted next over req0.
//  4. out_ready low 5 cycles mid-burst
//     -> out_valid held, beat_cnt frozen, no in_ready pulse; burst resumes intact.
//  5. rst_n low during beat 3 of a grant to 1
//     -> outputs 0 same cycle; after release, in_valid=0010 grants sel=1 from ptr=0.
//  6. ARB_OUT_REG_EN, all requesting
//     -> first out_valid 1 cycle later than non-reg build; identical data sequence.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter
//   Round-robin arbiter that shares one W-bit N:1 mux datapath among N
//   valid/ready requesters. A winner is picked in IDLE by scanning from the
//   round-robin pointer. Its grant is held for a burst of up to MAX_BURST
//   beats, or until that requester drops valid. One IDLE bubble cycle
//   separates consecutive grants.
//
// Optional build macro: ARB_OUT_REG_EN
//   When defined, a one-entry register slice sits on the output side.
//   Beats and release are counted on the input-side handshake. A held entry
//   keeps draining after the grant has returned to IDLE.
//
// Ports
//   clk        in   1     clock, all state on the rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   N     per-requester valid
//   in_data    in   N*W   requester i data at in_data[i*W +: W]
//   in_ready   out  N     per-requester ready (one-hot or zero)
//   out_valid  out  1     output beat valid
//   out_data   out  W     output data
//   out_ready  in   1     downstream ready
//   sel        out  SW    current grant index (mux select)
//   busy       out  1     high while a grant is held
module mux_4_1_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 4,
    parameter int MAX_BURST = 4,
    localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [SW-1:0]    sel,
    output logic             busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   ptr_reg, ptr_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [SW-1:0]   winner;
    logic            sel_valid;
    logic [W-1:0]    sel_data;
    logic            grant_ready;
    logic            beat;
    logic            last_beat;

    assign sel_valid = in_valid[sel_reg];
    assign sel_data  = in_data[sel_reg*W +: W];
    assign sel       = sel_reg;

`ifdef ARB_OUT_REG_EN
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;

    // The slice accepts a new entry when it is empty or is emptying this cycle.
    assign grant_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (beat) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    assign grant_ready = out_ready;
`endif

    // Input-side handshake of the granted requester.
    assign beat      = (state_reg == GRANT) && sel_valid && grant_ready;
    assign last_beat = (beat_cnt_reg == CW'(MAX_BURST - 1));

    // Winner is the first valid requester found when scanning upward from ptr.
    // The loop runs from the farthest offset down to the nearest offset,
    // so the nearest valid requester is the last one assigned.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (in_valid[idx[SW-1:0]]) begin
                winner = idx[SW-1:0];
            end
        end
    end

    // ready is steered only to the granted requester.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = (state_reg == GRANT) && (sel_reg == SW'(gi)) && grant_ready;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            sel_reg      <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        sel_next      = sel_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|in_valid) begin
                    sel_next      = winner;
                    beat_cnt_next = '0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                // A dropped valid ends the burst early. No beat happens that cycle.
                if (!sel_valid || (beat && last_beat)) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                    ptr_next      = (sel_reg == SW'(N - 1)) ? '0 : sel_reg + SW'(1);
                end else if (beat) begin
                    beat_cnt_next = beat_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg == GRANT);
`ifdef ARB_OUT_REG_EN
        out_valid = out_valid_q;
        out_data  = out_data_q;
`else
        out_valid = (state_reg == GRANT) && sel_valid;
        out_data  = (state_reg == GRANT) ? sel_data : '0;
`endif
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Testbench for mux_4_1_rr_arbiter (N=4, W=4, MAX_BURST=4).
// Requester i presents data {i[1:0], count}, where count is the number of
// beats that requester has transferred so far (mod 4).
// Stimulus pushes the expected beats and point probes into queues.
// A single negedge monitor compares them against the DUT.
module tb_mux_4_1_rr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     sel;
    logic           busy;

    mux_4_1_rr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester data model
    logic [1:0]   hs_cnt [N];
    logic [N-1:0] hs_pend;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            assign in_data[gi*W +: W] = {2'(gi), hs_cnt[gi]};
        end
    endgenerate

    initial begin
        for (int i = 0; i < N; i++) hs_cnt[i] = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_pend[i]) hs_cnt[i] = hs_cnt[i] + 2'd1;
            end
        end
    end

    // Scoreboard queues
    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
    } beat_t;

    typedef struct {
        int code;
        int val;
    } probe_t;

    localparam int P_OV = 0, P_IR = 1, P_BUSY = 2, P_SEL = 3, P_DATA = 4;

    beat_t  exp_q[$];
    probe_t probe_q[$];
    int     total;
    int     bad;
    bit     done;

    task automatic expb(input int s, input int d);
        beat_t b;
        b.sel  = 2'(s);
        b.data = 4'((s << 2) | d);
        exp_q.push_back(b);
    endtask

    task automatic probe(input int code, input int val);
        probe_t p;
        p.code = code;
        p.val  = val;
        probe_q.push_back(p);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    // Monitor: evaluates probes and output beats once per cycle, away from the edge
    initial begin
        int cycles;
        int act;
        beat_t e;
        probe_t p;
        total   = 0;
        bad     = 0;
        cycles  = 0;
        hs_pend = '0;
        forever begin
            @(negedge clk);
            cycles++;
            hs_pend = in_valid & in_ready;
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.code)
                    P_OV:    act = int'(out_valid);
                    P_IR:    act = int'(in_ready);
                    P_BUSY:  act = int'(busy);
                    P_SEL:   act = int'(sel);
                    default: act = int'(out_data);
                endcase
                total++;
                if (act != p.val) begin
                    bad++;
                    $display("FAIL probe%0d t=%0t actual=%0d required=%0d", p.code, $time, act, p.val);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat t=%0t actual=data %h required=no beat", $time, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data) begin
                        bad++;
                        $display("FAIL beat_data t=%0t actual=%h required=%h", $time, out_data, e.data);
                    end
`ifndef ARB_OUT_REG_EN
                    total++;
                    if (sel !== e.sel) begin
                        bad++;
                        $display("FAIL beat_sel t=%0t actual=%0d required=%0d", $time, sel, e.sel);
                    end
`endif
                end
            end
            if (done || cycles > 5000) begin
                total++;
                if (!done) begin
                    bad++;
                    $display("FAIL timeout actual=%0d cycles required=done", cycles);
                end
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL missing_beats actual=%0d left required=0", exp_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        done      = 1'b0;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        // Reset state
        probe(P_OV, 0);
        probe(P_IR, 0);
        probe(P_BUSY, 0);
        probe(P_SEL, 0);
        probe(P_DATA, 0);
        cyc(2);
        rst_n = 1'b1;

        // 1: single requester, two grants with an IDLE bubble between them
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        for (int g = 0; g < 2; g++) for (int k = 0; k < 4; k++) expb(0, k);
        probe(P_BUSY, 0);
        cyc(1);
        probe(P_BUSY, 1);
        probe(P_SEL, 0);
        probe(P_IR, 1);
`ifdef ARB_OUT_REG_EN
        probe(P_OV, 0);
        cyc(1);
        probe(P_OV, 1);
        cyc(3);
`else
        probe(P_OV, 1);
        cyc(4);
        probe(P_OV, 0);
`endif
        probe(P_BUSY, 0);
        cyc(5);
        in_valid = 4'b0000;
        cyc(3);

        // 2: all requesting, order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 4; k++) expb(0, k);
        for (int k = 0; k < 4; k++) expb(1, k);
        for (int k = 0; k < 4; k++) expb(2, k);
        for (int k = 0; k < 4; k++) expb(3, k);
        for (int k = 0; k < 4; k++) expb(0, k);
        in_valid = 4'b1111;
        cyc(25);
        in_valid = 4'b0000;
        cyc(3);

        // 3: requester 2 drops after 2 beats; requester 3 wins over 0
        do_reset();
        expb(2, 0);
        expb(2, 1);
        for (int k = 0; k < 4; k++) expb(3, k);
        for (int k = 0; k < 4; k++) expb(0, k);
        in_valid = 4'b0100;
        cyc(3);
        in_valid = 4'b1001;
        cyc(1);
        probe(P_BUSY, 0);
        cyc(1);
        probe(P_SEL, 3);
        probe(P_BUSY, 1);
        cyc(4);
        in_valid = 4'b0001;
        cyc(5);
        in_valid = 4'b0000;
        cyc(3);

        // 4: out_ready low for 5 cycles mid-burst
        do_reset();
        for (int k = 0; k < 4; k++) expb(1, k);
        in_valid = 4'b0010;
        cyc(3);
        out_ready = 1'b0;
        repeat (5) begin
            probe(P_OV, 1);
            probe(P_IR, 0);
`ifdef ARB_OUT_REG_EN
            probe(P_DATA, 5);
`else
            probe(P_DATA, 6);
`endif
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(2);
        in_valid = 4'b0000;
        cyc(3);

        // 5: reset during beat 3 of a grant to requester 1
        do_reset();
        expb(1, 0);
`ifndef ARB_OUT_REG_EN
        expb(1, 1);
`endif
        expb(1, 2);
        expb(1, 3);
        expb(1, 0);
        expb(1, 1);
        in_valid = 4'b0010;
        cyc(3);
        rst_n = 1'b0;
        probe(P_OV, 0);
        probe(P_IR, 0);
        probe(P_BUSY, 0);
        probe(P_SEL, 0);
        probe(P_DATA, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        probe(P_SEL, 1);
        probe(P_BUSY, 1);
        cyc(4);
        in_valid = 4'b0000;
        cyc(3);

        done = 1'b1;
    end

endmodule
